output_layer_collector: RTL and testbench
=========================================

# output_layer_collector

Assembles the serial activation stream of the output layer into the flat `output_activations` bus. The output layer emits one signed activation per accepted beat, neuron 0 first. This block packs the beats into a staging register and commits a complete frame to a held output register, with a valid/ready handshake to the downstream argmax and display path. It double-buffers, so the next frame can be collected while the previous one is still held.

## Interface
- `NEURON_NUMBER`, 10, activations per frame (≥2)
- `RESOLUTION`, 8, bits per signed activation
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: beat available.
- `in_ready` out 1: collector accepts the beat.
- `in_data` in `RESOLUTION`: signed activation for the current slot.
- `in_last` in 1: marks the final beat of a frame.
- `out_valid` out 1: `output_activations` holds a committed frame.
- `out_ready` in 1: consumer takes the frame.
- `output_activations` out `RESOLUTION*NEURON_NUMBER`: neuron *i* occupies bits `[i*RESOLUTION +: RESOLUTION]`.
- `frame_error` out 1: one-cycle pulse when a frame length violation is detected.

## Operation
- **Handshakes**
  - Input beat accepted when `in_valid && in_ready`.
  - Output frame consumed when `out_valid && out_ready`.
- **Slot counter** `idx`
  - Width is `$clog2(NEURON_NUMBER)`.
  - Each accepted beat writes `in_data` into staging slot `idx`, then `idx` increments.
  - `idx` resets to 0 on commit, on error, and on reset.
- **FSM states**
  - **COLLECT**: `in_ready=1`.
    - Accepted beat with `idx<N-1` and `in_last=1` (early last): pulse `frame_error`, discard the staging contents, `idx←0`, stay in COLLECT.
    - Accepted beat with `idx==N-1` and `in_last=1`:
      - If the output register is free this cycle, commit: staging → `output_activations`, `out_valid←1`, stay in COLLECT.
      - "Free" means `!out_valid`, or `out_valid && out_ready` in the same cycle.
      - Otherwise go to WAIT_COMMIT.
    - Accepted beat with `idx==N-1` and `in_last=0` (missing last): pulse `frame_error`, discard, go to DRAIN.
  - **WAIT_COMMIT**: `in_ready=0`; staging is held.
    - When `!out_valid || out_ready`, commit with `out_valid=1` and return to COLLECT.
    - Commit and consumption in the same cycle: the new frame replaces the old one with no gap.
  - **DRAIN**: `in_ready=1`.
    - Accepted beats are discarded.
    - The accepted beat with `in_last=1` returns the FSM to COLLECT with `idx=0`; no second error pulse.
- **Output handshake**
  - `out_valid` clears on `out_valid && out_ready` unless a commit occurs in the same cycle.
  - `output_activations` changes only on commit. It is stable whenever `out_valid=1` and no handshake has occurred.
- **Data handling**: data is stored verbatim. No sign extension, saturation or arithmetic.

## Timing
- Reset values:
  - FSM = COLLECT, `idx=0`.
  - `in_ready=1` (decoded from state).
  - `out_valid=0`, `output_activations=0`, `frame_error=0`.
  - Staging = 0.
- Latency: `out_valid` rises on the clock edge that accepts the last beat (registered, visible the next cycle).
- Throughput: one beat per cycle. Back-to-back frames reach N cycles per frame when the consumer holds `out_ready=1`.
- `frame_error` is registered and asserts the cycle after the offending beat, for exactly one cycle.
- `in_ready` is combinational from state only. It does not depend on `in_valid`, which prevents combinational loops.
- Reset asserted mid-frame or during WAIT_COMMIT returns all state to reset values immediately. A partial frame is lost and `out_valid` drops asynchronously.

## Structure
- Shared package holds:
  - `NEURON_NUMBER` and `RESOLUTION` defaults.
  - FSM state encoding (COLLECT, WAIT_COMMIT, DRAIN; 2 bits).
- Single flat module, no sub-modules.

## Test plan
- **Single frame:** 10 beats with values −128, −1, 0, 1, …, 127 and `in_last` on beat 10, `out_ready=1` → `out_valid` for 1 cycle; bus slot 0 = 8'h80, slot 9 = 8'h7F; `frame_error=0`.
- **Backpressure:**
  - Stimulus: `out_ready=0`; frame A, then frame B streamed immediately.
  - Expected: frame A held stable; after B's last beat `in_ready=0` (WAIT_COMMIT).
  - Expected: when `out_ready=1`, A is consumed and B is committed the same cycle; `out_valid` stays 1; `in_ready` returns to 1 the next cycle.
- **Early last:** `in_last` on beat 4 → `frame_error` pulses 1 cycle; the next 10 beats form a correct frame; output unchanged until that commit.
- **Missing last:** 12 beats with `in_last` only on beat 12 → one `frame_error` pulse after beat 10; beats 11–12 dropped; no `out_valid`; the following good frame is committed correctly.
- **Reset mid-operation:** `rst_n` low after 5 beats, and again during WAIT_COMMIT → `out_valid=0`, bus = 0, `in_ready=1`, `idx=0`; a subsequent full frame is collected correctly.

Source files
------------

// File: rtl/output_layer_collector_pkg.sv
// Shared defaults and FSM encoding for the output-layer activation collector.
package output_layer_collector_pkg;

    localparam int unsigned DefNeuronNumber = 10;
    localparam int unsigned DefResolution   = 8;

    typedef enum logic [1:0] {
        StCollect    = 2'd0,
        StWaitCommit = 2'd1,
        StDrain      = 2'd2
    } state_e;

endpackage

// File: rtl/output_layer_collector.sv
// Packs the serial output-layer activation stream into a held, double-buffered frame
// register with valid/ready handshakes on both sides and frame-length error detection.
module output_layer_collector
    import output_layer_collector_pkg::*;
#(
    parameter int unsigned NEURON_NUMBER = DefNeuronNumber,
    parameter int unsigned RESOLUTION    = DefResolution
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [RESOLUTION-1:0]             in_data_i,
    input  logic                              in_last_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [RESOLUTION*NEURON_NUMBER-1:0] output_activations_o,
    output logic                              frame_error_o
);

    localparam int unsigned IdxW = $clog2(NEURON_NUMBER);
    localparam int unsigned BusW = RESOLUTION * NEURON_NUMBER;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NEURON_NUMBER - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [BusW-1:0] staging_q, staging_d;
    logic [BusW-1:0] out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_error_q, frame_error_d;

    logic [BusW-1:0] staging_wr;
    logic            accept;
    logic            out_free;

    assign in_ready_o           = (state_q != StWaitCommit);
    assign accept               = in_valid_i && in_ready_o;
    // Output register can take a new frame if empty or being drained this cycle.
    assign out_free             = !out_valid_q || out_ready_i;
    assign out_valid_o          = out_valid_q;
    assign output_activations_o = out_q;
    assign frame_error_o        = frame_error_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        staging_d     = staging_q;
        out_d         = out_q;
        out_valid_d   = out_valid_q && !out_ready_i;
        frame_error_d = 1'b0;

        staging_wr = staging_q;
        staging_wr[idx_q*RESOLUTION +: RESOLUTION] = in_data_i;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (idx_q != LastIdx) begin
                        if (in_last_i) begin
                            frame_error_d = 1'b1;
                            staging_d     = '0;
                            idx_d         = '0;
                        end else begin
                            staging_d = staging_wr;
                            idx_d     = idx_q + IdxW'(1);
                        end
                    end else if (in_last_i) begin
                        staging_d = staging_wr;
                        idx_d     = '0;
                        if (out_free) begin
                            out_d       = staging_wr;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = StWaitCommit;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        staging_d     = '0;
                        idx_d         = '0;
                        state_d       = StDrain;
                    end
                end
            end
            StWaitCommit: begin
                if (out_free) begin
                    out_d       = staging_q;
                    out_valid_d = 1'b1;
                    state_d     = StCollect;
                end
            end
            StDrain: begin
                // Overlong frame: swallow beats up to and including its last one.
                if (accept && in_last_i) begin
                    state_d = StCollect;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StCollect;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StCollect;
            idx_q         <= '0;
            staging_q     <= '0;
            out_q         <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            staging_q     <= staging_d;
            out_q         <= out_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

endmodule

// File: tb/tb_output_layer_collector.sv
// Self-checking bench: directed table, hand-written corner sequences and random traffic,
// all checked every cycle against a queue-based frame model.
module tb_output_layer_collector;

    localparam int N = 10;
    localparam int R = 8;
    localparam int W = N * R;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_last, out_valid, out_ready, frame_error;
    logic [R-1:0] in_data;
    logic [W-1:0] acts;

    always #5 clk = ~clk;

    output_layer_collector #(.NEURON_NUMBER(N), .RESOLUTION(R)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .in_valid_i           (in_valid),
        .in_ready_o           (in_ready),
        .in_data_i            (in_data),
        .in_last_i            (in_last),
        .out_valid_o          (out_valid),
        .out_ready_i          (out_ready),
        .output_activations_o (acts),
        .frame_error_o        (frame_error)
    );

    int checks = 0;
    int passed = 0;

    // Frame-level reference model.
    logic [R-1:0] cur[$];
    bit           dropping;
    bit           pend_v;
    logic [W-1:0] pend_f;
    bit           m_valid;
    logic [W-1:0] m_out;
    bit           m_err;

    typedef struct {
        bit           v;
        bit           l;
        logic [R-1:0] d;
        bit           ordy;
        bit           e_ov;
        bit           e_err;
        bit           e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        cur.delete();
        dropping = 0;
        pend_v   = 0;
        pend_f   = '0;
        m_valid  = 0;
        m_out    = '0;
        m_err    = 0;
    endtask

    task automatic model_clock();
        bit           free;
        bit           nv;
        logic [W-1:0] frame;
        free  = !m_valid || out_ready;
        nv    = m_valid && !out_ready;
        m_err = 0;
        if (pend_v) begin
            if (free) begin
                m_out  = pend_f;
                nv     = 1;
                pend_v = 0;
            end
        end else if (in_valid) begin
            if (dropping) begin
                if (in_last) dropping = 0;
            end else begin
                cur.push_back(in_data);
                if (cur.size() == N) begin
                    if (in_last) begin
                        frame = '0;
                        for (int i = 0; i < N; i++) frame[i*R +: R] = cur[i];
                        if (free) begin
                            m_out = frame;
                            nv    = 1;
                        end else begin
                            pend_v = 1;
                            pend_f = frame;
                        end
                    end else begin
                        m_err    = 1;
                        dropping = 1;
                    end
                    cur.delete();
                end else if (in_last) begin
                    m_err = 1;
                    cur.delete();
                end
            end
        end
        m_valid = nv;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".in_ready"}, W'(in_ready), W'(!pend_v));
        check({tag, ".out_valid"}, W'(out_valid), W'(m_valid));
        check({tag, ".frame_error"}, W'(frame_error), W'(m_err));
        check({tag, ".bus"}, acts, m_out);
    endtask

    task automatic drive(input bit v, input bit l, input logic [R-1:0] d, input bit ordy,
                         input string tag);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        model_clock();
        #1;
        compare_model(tag);
    endtask

    task automatic send_frame(input int base, input bit ordy, input string tag);
        for (int i = 0; i < N; i++) drive(1, i == N - 1, R'(base + i * 7), ordy, tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ".rst_out_valid"}, W'(out_valid), '0);
        check({tag, ".rst_bus"}, acts, '0);
        check({tag, ".rst_in_ready"}, W'(in_ready), W'(1));
        check({tag, ".rst_frame_error"}, W'(frame_error), '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] frame_of(input int base);
        logic [W-1:0] f;
        for (int i = 0; i < N; i++) f[i*R +: R] = R'(base + i * 7);
        return f;
    endfunction

    initial begin
        logic [R-1:0] sf[N];
        int           err_cnt;
        bit           seen_valid;
        int           cnt;
        bit           v, l, acc;

        sf = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7F};
        for (int i = 0; i < N; i++)
            vecs.push_back('{v: 1, l: i == N - 1, d: sf[i], ordy: 1,
                             e_ov: i == N - 1, e_err: 0, e_rdy: 1});
        vecs.push_back('{v: 0, l: 0, d: 8'h00, ordy: 1, e_ov: 0, e_err: 0, e_rdy: 1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{v: 1, l: i == 3, d: 8'(8'h40 + i), ordy: 1,
                             e_ov: 0, e_err: i == 3, e_rdy: 1});
        vecs.push_back('{v: 0, l: 0, d: 8'h00, ordy: 1, e_ov: 0, e_err: 0, e_rdy: 1});

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset.in_ready", W'(in_ready), W'(1));
        check("reset.out_valid", W'(out_valid), '0);
        check("reset.frame_error", W'(frame_error), '0);
        check("reset.bus", acts, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: single frame then early last.
        foreach (vecs[k]) begin
            drive(vecs[k].v, vecs[k].l, vecs[k].d, vecs[k].ordy, "table");
            check($sformatf("vec%0d.out_valid", k), W'(out_valid), W'(vecs[k].e_ov));
            check($sformatf("vec%0d.frame_error", k), W'(frame_error), W'(vecs[k].e_err));
            check($sformatf("vec%0d.in_ready", k), W'(in_ready), W'(vecs[k].e_rdy));
            if (k == N - 1) begin
                check("single.slot0", W'(acts[0 +: R]), W'(8'h80));
                check("single.slot9", W'(acts[(N-1)*R +: R]), W'(8'h7F));
            end
        end
        send_frame(3, 1, "after_early");
        check("after_early.bus", acts, frame_of(3));
        drive(0, 0, 0, 1, "idle");

        // Backpressure: A held, B waits, then swap in one cycle.
        send_frame(20, 0, "bpA");
        send_frame(90, 0, "bpB");
        check("bp.in_ready_wait", W'(in_ready), '0);
        check("bp.hold_A", acts, frame_of(20));
        drive(1, 0, 8'h55, 0, "bp_hold");
        check("bp.still_A", acts, frame_of(20));
        drive(0, 0, 0, 1, "bp_swap");
        check("bp.swap_valid", W'(out_valid), W'(1));
        check("bp.swap_B", acts, frame_of(90));
        check("bp.ready_back", W'(in_ready), W'(1));
        drive(0, 0, 0, 1, "bp_drain");

        // Missing last: 12 beats, last only on beat 12.
        err_cnt    = 0;
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, i == 11, 8'(8'hA0 + i), 1, "missing");
            if (frame_error) err_cnt++;
            if (out_valid) seen_valid = 1;
        end
        drive(0, 0, 0, 1, "missing_idle");
        if (frame_error) err_cnt++;
        check("missing.err_pulses", W'(err_cnt), W'(1));
        check("missing.no_valid", W'(seen_valid), '0);
        send_frame(50, 1, "after_missing");
        check("after_missing.bus", acts, frame_of(50));

        // Reset mid-frame, then during WAIT_COMMIT.
        for (int i = 0; i < 5; i++) drive(1, 0, 8'(i), 1, "partial");
        do_reset("rst_mid");
        send_frame(60, 1, "after_rst1");
        check("after_rst1.bus", acts, frame_of(60));
        send_frame(70, 0, "wcA");
        send_frame(80, 0, "wcB");
        check("wc.in_ready", W'(in_ready), '0);
        do_reset("rst_wait");
        send_frame(100, 1, "after_rst2");
        check("after_rst2.bus", acts, frame_of(100));

        // Random traffic against the model.
        cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            l   = ($urandom_range(0, 24) == 0) ? 1'b1 : (cnt >= N - 1);
            acc = v && !pend_v;
            drive(v, l, R'($urandom), $urandom_range(0, 2) != 0, "rand");
            if (acc) cnt = l ? 0 : cnt + 1;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
